// File: rtl/state_seq_detector_if.sv
// rtl/state_seq_detector_if.sv - character stream in / detection strobe out bundle for state_seq_detector
interface state_seq_detector_if;
    logic [7:0] data;
    logic       flag;

    // Character source drives data and observes the strobe
    modport master (
        output data,
        input  flag
    );

    // Detector samples data and raises the strobe
    modport slave (
        input  data,
        output flag
    );
endinterface

// File: rtl/state_seq_detector.sv
// rtl/state_seq_detector.sv - serial detector for the ASCII word "state" with a one-cycle flag strobe
module state_seq_detector (
    input  logic                      clk,
    input  logic                      rst_n,
    state_seq_detector_if.slave       bus
);

    localparam logic [7:0] CHAR_S = 8'h73;
    localparam logic [7:0] CHAR_T = 8'h74;
    localparam logic [7:0] CHAR_A = 8'h61;
    localparam logic [7:0] CHAR_E = 8'h65;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S    = 3'd1,
        ST   = 3'd2,
        STA  = 3'd3,
        STAT = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   flag_q;
    logic   flag_d;

    logic   is_s;

    // 's' is the only character that can restart a match after a miss,
    // because no proper prefix of "state" is also a suffix of it.
    assign is_s = (bus.data == CHAR_S);

    // Next-state decode; any miss falls back to S on 's', otherwise IDLE
    always_comb begin
        state_d = IDLE;
        flag_d  = 1'b0;
        case (state_q)
            IDLE: state_d = is_s ? S : IDLE;
            S: begin
                if (bus.data == CHAR_T) state_d = ST;
                else if (is_s)          state_d = S;
                else                    state_d = IDLE;
            end
            ST: begin
                if (bus.data == CHAR_A) state_d = STA;
                else if (is_s)          state_d = S;
                else                    state_d = IDLE;
            end
            STA: begin
                if (bus.data == CHAR_T) state_d = STAT;
                else if (is_s)          state_d = S;
                else                    state_d = IDLE;
            end
            STAT: begin
                if (bus.data == CHAR_E) state_d = DONE;
                else if (is_s)          state_d = S;
                else                    state_d = IDLE;
            end
            DONE: state_d = is_s ? S : IDLE;
            // Unused encodings 6 and 7 recover to IDLE regardless of data
            default: state_d = IDLE;
        endcase
        // Moore strobe, registered so it lines up with the DONE cycle
        flag_d = (state_d == DONE);
    end

    // State and strobe registers; rst_n is active-high despite its name
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
        end
    end

    assign bus.flag = flag_q;

endmodule

// File: tb/tb_state_seq_detector.sv
// tb/tb_state_seq_detector.sv - scoreboard bench for state_seq_detector against a history-window model
module tb_state_seq_detector;

    logic clk;
    logic rst_n;
    state_seq_detector_if bus ();

    state_seq_detector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks     = 0;
    int   failures   = 0;
    int   exp_pulses = 0;
    int   obs_pulses = 0;
    logic sb[$];
    byte  hist[$];
    logic prev_flag  = 1'b0;
    byte  word[5]    = '{8'h73, 8'h74, 8'h61, 8'h74, 8'h65};

    // Reference: flag after an edge is 1 exactly when the last five
    // characters accepted since reset spell "state".
    task automatic step(input byte c, input logic r);
        logic want;
        @(negedge clk);
        bus.data = c;
        rst_n    = r;
        @(posedge clk);
        #1;
        if (r) begin
            hist.delete();
            want = 1'b0;
        end else begin
            hist.push_back(c);
            if (hist.size() > 5) void'(hist.pop_front());
            want = 1'b1;
            if (hist.size() != 5) want = 1'b0;
            else for (int i = 0; i < 5; i++) if (hist[i] != word[i]) want = 1'b0;
        end
        if (want) exp_pulses++;
        sb.push_back(want);
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++) step(s[i], 1'b0);
    endtask

    task automatic reset_cycles(input int n, input byte c);
        for (int i = 0; i < n; i++) step(c, 1'b1);
    endtask

    // Monitor: compare every observed flag sample against the queued expectation
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            logic want;
            want = sb.pop_front();
            checks++;
            if (bus.flag !== want) begin
                failures++;
                $display("FAIL flag_cycle t=%0t actual=%b required=%b", $time, bus.flag, want);
            end
            checks++;
            if (prev_flag === 1'b1 && bus.flag === 1'b1) begin
                failures++;
                $display("FAIL flag_double t=%0t actual=11 required=not both high", $time);
            end
            if (bus.flag === 1'b1) obs_pulses++;
            prev_flag = bus.flag;
        end
    end

    initial begin
        byte pool[8];
        byte c;
        int  budget;
        pool = '{8'h73, 8'h74, 8'h61, 8'h74, 8'h65, 8'h53, 8'h45, 8'h73};
        rst_n    = 1'b1;
        bus.data = 8'h00;

        // Reset absorbs the 's'; the following "tate" must not fire
        reset_cycles(5, 8'h73);
        feed("tate");

        reset_cycles(1, 8'h00);
        feed("astattstateaa");

        reset_cycles(1, 8'h00);
        feed("statestate");

        reset_cycles(1, 8'h00);
        feed("ststate");

        reset_cycles(1, 8'h00);
        feed("StatestatEstats");

        // Mid-word reset discards the partial match
        reset_cycles(1, 8'h00);
        feed("stat");
        reset_cycles(1, 8'h65);
        feed("e");

        // Randomized stream biased toward word characters, with rare resets
        reset_cycles(1, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) c = byte'($urandom_range(0, 255));
            else if ($urandom_range(0, 2) == 0) c = word[$urandom_range(0, 4)];
            else c = pool[$urandom_range(0, 7)];
            step(c, ($urandom_range(0, 199) == 0));
        end
        // Guarantee pulses appear within the random section too
        for (int i = 0; i < 20; i++) begin
            feed("state");
            if ($urandom_range(0, 1) == 1) feed("s");
        end

        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d left required=0", sb.size());
        end
        checks++;
        if (obs_pulses != exp_pulses) begin
            failures++;
            $display("FAIL pulse_count actual=%0d required=%0d", obs_pulses, exp_pulses);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/state_seq_detector.md
Name: state_seq_detector

Overview:
- Serial ASCII sequence detector for the five-character word "state" (0x73 0x74 0x61 0x74 0x65).
- Samples one 8-bit character per clock and pulses flag for one cycle when the final 'e' of the word completes.
- Sits downstream of a byte/character source, for example a UART RX data path. Its flag output is consumed as a single-cycle event strobe.

Parameters:
- None. The target word is fixed to "state".

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset. One clock; reset is synchronous and active-high. The name keeps the codebase convention, but rst_n=1 means reset asserted.
- data  input  8  ASCII character. Sampled on every rising edge; no valid qualifier, so every cycle is one character.
- flag  output  1  detection strobe; high for exactly one cycle after "state" completes.

Behaviour:
- States, binary encoded, 3-bit state register:
  - IDLE: nothing matched
  - S: "s" matched
  - ST: "st" matched
  - STA: "sta" matched
  - STAT: "stat" matched
  - DONE: "state" matched
- Reset, sampled on the rising edge with rst_n=1: state <= IDLE, flag <= 0. This takes priority over any data value. A reset mid-word discards the partial match.
- Transitions, evaluated on each rising edge with reset deasserted:
  - IDLE: 's' -> S; else IDLE.
  - S: 't' -> ST; 's' -> S; else IDLE.
  - ST: 'a' -> STA; 's' -> S; else IDLE.
  - STA: 't' -> STAT; 's' -> S; else IDLE.
  - STAT: 'e' -> DONE; 's' -> S; else IDLE.
  - DONE: 's' -> S; else IDLE.
- Mismatch rule: on any mismatch the FSM falls back to S if the current character is 's', otherwise IDLE. This is the only valid overlap, because "state" has no proper prefix that is also a suffix.
- Back-to-back words ("statestate") are both detected.
- flag is a Moore output driven from a register: flag <= (next_state == DONE).
  - flag goes high on the rising edge where 'e' is sampled in STAT.
  - It stays high for exactly one clock, the cycle the FSM is in DONE.
  - It cannot stay high for two consecutive cycles.
- Latency: 'e' sampled at edge N -> flag high from edge N to edge N+1.
- Comparison is exact 8-bit equality. Case-sensitive: 'S' (0x53) does not match. Non-printable values are treated as mismatches.
- Any unused state encoding recovers to IDLE on the next edge, with flag=0.

Test Plan:
- Reset: hold rst_n=1 for 5 cycles with data='s' -> state IDLE, flag=0 throughout. Release, then feed t,a,t,e -> flag stays 0, because the 's' was absorbed during reset.
- Mixed stream: after reset, feed a,s,t,a,t,t,s,t,a,t,e,a,a, one per clock -> flag=0 through the first "stat" + 't' mismatch. flag=1 for exactly the one cycle after 'e' is sampled (11th character), then 0 for the trailing a,a.
- Back-to-back: feed s,t,a,t,e,s,t,a,t,e -> two single-cycle flag pulses, 5 cycles apart.
- Fallback on 's': feed s,t,s,t,a,t,e -> one flag pulse after 'e'. The second 's' restarts the match.
- Case and near-miss: feed S,t,a,t,e then s,t,a,t,E then s,t,a,t,s -> flag never asserts.
- Mid-word reset: feed s,t,a,t, assert rst_n=1 for 1 cycle, then feed e -> flag stays 0.
